simd_alu_pipe: RTL and testbench

Two-stage pipelined SIMD integer execute unit sitting directly downstream of the SIMD operand organizer in the decode/execute path. Consumes the already-reorganized, already-masked 64-bit `rs1`/`rs2` pair, performs a lane-wise add/sub/min/max at the lane width selected by `funct3[1:0]`, and delivers the result to writeback over a valid/ready handshake. It also keeps per-lane sticky overflow status for the SIMD CSR.

---
 rtl/simd_alu_pipe.sv | 181 ++++++++++++++++++
 tb/tb_simd_alu_pipe.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: two-stage SIMD integer execute unit (lane-wise add/sub/min/max)
// with valid/ready flow control and per-16-bit-slot sticky overflow flags.
// Optional feature: define SIMD_SAT_EN to saturate add/sub per lane on overflow.

`ifndef SIMD_DATA_WIDTH
`define SIMD_DATA_WIDTH 64
`endif
`ifndef SIMD16
`define SIMD16 2'b00
`endif
`ifndef SIMD32
`define SIMD32 2'b01
`endif

module simd_alu_pipe #(
   parameter int DATA_W = `SIMD_DATA_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] rs1,
   input  logic [DATA_W-1:0] rs2,
   input  logic [2:0]        funct3,
   input  logic [1:0]        op,
   input  logic [4:0]        rd_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic [4:0]        out_tag,
   output logic [3:0]        ovf_sticky,
   input  logic              sticky_clr
);

   // S1 operand stage
   logic              s1_valid;
   logic [DATA_W-1:0] s1_rs1;
   logic [DATA_W-1:0] s1_rs2;
   logic [1:0]        s1_width;
   logic [1:0]        s1_op;
   logic [4:0]        s1_tag;

   // S1 combinational result and S2 overflow vector
   logic [DATA_W-1:0] s1_res;
   logic [3:0]        s1_ovf;
   logic [3:0]        s2_ovf;
   logic [DATA_W:0]   lane_out;

   logic s1_advance;
   logic in_fire;
   logic out_fire;
   logic funct3_unused;

   assign funct3_unused = funct3[2];

   assign s1_advance = s1_valid && (!out_valid || out_ready);
   assign in_ready   = !s1_valid || s1_advance;
   assign in_fire    = in_valid && in_ready;
   assign out_fire   = out_valid && out_ready;

   // One lane of width w held in the low bits of a and b (upper bits zero).
   // Returns {overflow, lane result}; the result is confined to the low w bits.
   function automatic logic [DATA_W:0] lane_op(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic [1:0]        lop,
      input int unsigned       w
   );
      logic [DATA_W-1:0] mask;
      logic [DATA_W-1:0] top;
      logic [DATA_W-1:0] sum;
      logic [DATA_W-1:0] r;
      logic              sa, sb, sr, lt, ovf;
      mask = (w >= DATA_W) ? '1 : ((DATA_W'(1) << w) - DATA_W'(1));
      top  = mask ^ (mask >> 1);
      sum  = (lop[0] ? (a - b) : (a + b)) & mask;
      sa   = |(a & top);
      sb   = |(b & top);
      sr   = |(sum & top);
      // same sign: unsigned order of the zero-extended lanes equals signed order
      lt   = (sa != sb) ? sa : (a < b);
      ovf  = 1'b0;
      r    = sum;
      case (lop)
         2'b00:   ovf = (sa == sb) && (sr != sa);
         2'b01:   ovf = (sa != sb) && (sr != sa);
         2'b10:   r = lt ? a : b;
         default: r = lt ? b : a;
      endcase
`ifdef SIMD_SAT_EN
      if (ovf) begin
         r = sa ? top : (mask >> 1);
      end
`endif
      return {ovf, r};
   endfunction

   // S1 operand capture; data only loads on an accepted transfer so a held stage stays put
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_rs1   <= '0;
         s1_rs2   <= '0;
         s1_width <= '0;
         s1_op    <= '0;
         s1_tag   <= '0;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_rs1   <= rs1;
            s1_rs2   <= rs2;
            s1_width <= funct3[1:0];
            s1_op    <= op;
            s1_tag   <= rd_tag;
         end else if (s1_advance) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Lane-wise execute on the S1 operands; no carry crosses a lane boundary
   always_comb begin
      s1_res   = '0;
      s1_ovf   = '0;
      lane_out = '0;
      case (s1_width)
         `SIMD16: begin
            for (int unsigned i = 0; i < 4; i++) begin
               lane_out = lane_op(DATA_W'(16'(s1_rs1 >> (16 * i))),
                                  DATA_W'(16'(s1_rs2 >> (16 * i))), s1_op, 16);
               s1_res   = s1_res | (DATA_W'(lane_out[15:0]) << (16 * i));
               s1_ovf   = s1_ovf | (4'(lane_out[DATA_W]) << i);
            end
         end
         `SIMD32: begin
            for (int unsigned i = 0; i < 2; i++) begin
               lane_out = lane_op(DATA_W'(32'(s1_rs1 >> (32 * i))),
                                  DATA_W'(32'(s1_rs2 >> (32 * i))), s1_op, 32);
               s1_res   = s1_res | (DATA_W'(lane_out[31:0]) << (32 * i));
               s1_ovf   = s1_ovf | (4'({2{lane_out[DATA_W]}}) << (2 * i));
            end
         end
         default: begin
            lane_out = lane_op(s1_rs1, s1_rs2, s1_op, DATA_W);
            s1_res   = lane_out[DATA_W-1:0];
            s1_ovf   = {4{lane_out[DATA_W]}};
         end
      endcase
   end

   // S2 result stage; holds result/tag while writeback stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         out_tag   <= '0;
         s2_ovf    <= '0;
      end else begin
         if (s1_advance) begin
            out_valid <= 1'b1;
            result    <= s1_res;
            out_tag   <= s1_tag;
            s2_ovf    <= s1_ovf;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Sticky overflow: a coincident clear drops old flags but keeps the new ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky <= '0;
      end else if (out_fire) begin
         ovf_sticky <= (sticky_clr ? 4'b0000 : ovf_sticky) | s2_ovf;
      end else if (sticky_clr) begin
         ovf_sticky <= '0;
      end
   end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// tb_simd_alu_pipe: scoreboard bench for simd_alu_pipe (queue of expected results
// pushed on accept, popped on output handshake) plus per-scenario tasks.

`ifndef SIMD16
`define SIMD16 2'b00
`endif
`ifndef SIMD32
`define SIMD32 2'b01
`endif

module tb_simd_alu_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] rs1;
   logic [63:0] rs2;
   logic [2:0]  funct3;
   logic [1:0]  op;
   logic [4:0]  rd_tag;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic [4:0]  out_tag;
   logic [3:0]  ovf_sticky;
   logic        sticky_clr;

   always #5 clk = ~clk;

   simd_alu_pipe #(.DATA_W(64)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .rs1        (rs1),
      .rs2        (rs2),
      .funct3     (funct3),
      .op         (op),
      .rd_tag     (rd_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .out_tag    (out_tag),
      .ovf_sticky (ovf_sticky),
      .sticky_clr (sticky_clr)
   );

   typedef struct packed {
      logic [63:0] res;
      logic [4:0]  tag;
      logic [3:0]  ovf;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned acc_edges[$];
   int unsigned out_edges[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   int unsigned hs_count = 0;
   logic [63:0] last_result = '0;
   logic [4:0]  last_tag = '0;
   logic [3:0]  exp_sticky = '0;

`ifdef SIMD_SAT_EN
   localparam logic [63:0] EXP_ADD16 = 64'h0002_7FFF_0000_0020;
   localparam logic [63:0] EXP_SUB32 = 64'h8000_0000_FFFF_FFFE;
`else
   localparam logic [63:0] EXP_ADD16 = 64'h0002_8000_0000_0020;
   localparam logic [63:0] EXP_SUB32 = 64'h7FFF_FFFF_FFFF_FFFE;
`endif

   // Reference model: each lane sign-extended into a wide signed value, exact
   // arithmetic, then range check against the lane's signed limits.
   function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] w, input logic [1:0] o,
                                 output logic [63:0] r, output logic [3:0] ov);
      int unsigned lw, n;
      logic [65:0] tmp;
      logic signed [65:0] ea, eb, f, hi, lo;
      logic [63:0] mask, lr;
      logic ovl;
      lw = (w == `SIMD16) ? 16 : (w == `SIMD32) ? 32 : 64;
      n = 64 / lw;
      mask = (lw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << lw) - 64'd1);
      hi = (66'sd1 <<< (lw - 1)) - 66'sd1;
      lo = -(66'sd1 <<< (lw - 1));
      r = '0;
      ov = '0;
      for (int unsigned k = 0; k < n; k++) begin
         tmp = {2'b00, (a >> (k * lw))};
         ea = $signed(tmp << (66 - lw));
         ea = ea >>> (66 - lw);
         tmp = {2'b00, (b >> (k * lw))};
         eb = $signed(tmp << (66 - lw));
         eb = eb >>> (66 - lw);
         case (o)
            2'b00: f = ea + eb;
            2'b01: f = ea - eb;
            2'b10: f = (ea < eb) ? ea : eb;
            default: f = (ea > eb) ? ea : eb;
         endcase
         ovl = !o[1] && ((f > hi) || (f < lo));
`ifdef SIMD_SAT_EN
         if (ovl) f = (f > hi) ? hi : lo;
`endif
         lr = 64'(f) & mask;
         r = r | (lr << (k * lw));
         if (lw == 16) ov[k] = ovl;
         else if (lw == 32) ov = ov | ({2{ovl}} << (2 * k));
         else ov = {4{ovl}};
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: evaluates the handshakes that the next rising edge will perform
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (in_valid && in_ready) begin
            model(rs1, rs2, funct3[1:0], op, e.res, e.ovf);
            e.tag = rd_tag;
            sb_q.push_back(e);
            acc_edges.push_back(cyc + 1);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected_output: result=%h tag=%0d, required no output", result, out_tag);
            end else begin
               e = sb_q.pop_front();
               if (result !== e.res || out_tag !== e.tag) begin
                  failures++;
                  $display("FAIL sb_result: got result=%h tag=%0d, required result=%h tag=%0d",
                           result, out_tag, e.res, e.tag);
               end
               exp_sticky = (sticky_clr ? 4'b0000 : exp_sticky) | e.ovf;
            end
            last_result = result;
            last_tag = out_tag;
            out_edges.push_back(cyc + 1);
            hs_count++;
         end else if (sticky_clr) begin
            exp_sticky = '0;
         end
      end
   end

   task automatic set_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f,
                         input logic [1:0] o, input logic [4:0] t);
      rs1 = a; rs2 = b; funct3 = f; op = o; rd_tag = t;
   endtask

   // Offer one op and return at posedge+1 after it has been accepted
   task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f,
                        input logic [1:0] o, input logic [4:0] t);
      logic acc;
      bit done;
      done = 0;
      set_op(a, b, f, o, t);
      in_valid = 1'b1;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) done = 1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++; failures++;
         $display("FAIL drive_timeout: op tag=%0d not accepted, required accept within 100 cycles", t);
      end
   endtask

   task automatic wait_drain();
      bit done;
      done = 0;
      for (int n = 0; n < 100 && !done; n++) begin
         if (sb_q.size() == 0 && !out_valid) done = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL drain_timeout: %0d results pending, required 0", sb_q.size());
      end
   endtask

   task automatic check_sticky(input string name, input logic [3:0] req);
      checks++;
      if (ovf_sticky !== req) begin
         failures++;
         $display("FAIL %s: ovf_sticky=%b, required %b", name, ovf_sticky, req);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
      set_op('0, '0, '0, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checks += 5;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
      if (result !== 64'h0) begin failures++; $display("FAIL reset_result: got %h, required 0", result); end
      if (out_tag !== 5'h0) begin failures++; $display("FAIL reset_out_tag: got %0d, required 0", out_tag); end
      if (ovf_sticky !== 4'h0) begin failures++; $display("FAIL reset_sticky: got %b, required 0000", ovf_sticky); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_simd16_add();
      out_ready = 1'b1;
      drive(64'h0001_7FFF_FFFF_0010, 64'h0001_0001_0001_0010, {1'b1, `SIMD16}, 2'b00, 5'd3);
      wait_drain();
      checks += 2;
      if (last_result !== EXP_ADD16) begin failures++; $display("FAIL simd16_add: got %h, required %h", last_result, EXP_ADD16); end
      if (last_tag !== 5'd3) begin failures++; $display("FAIL simd16_add_tag: got %0d, required 3", last_tag); end
      check_sticky("simd16_add_sticky", 4'b0100);
   endtask

   task automatic test_simd32_sub();
      drive(64'h8000_0000_0000_0005, 64'h0000_0001_0000_0007, {1'b0, `SIMD32}, 2'b01, 5'd17);
      wait_drain();
      checks++;
      if (last_result !== EXP_SUB32) begin failures++; $display("FAIL simd32_sub: got %h, required %h", last_result, EXP_SUB32); end
      check_sticky("simd32_sub_sticky", 4'b1100);
   endtask

   task automatic test_scalar_max();
      drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b011, 2'b11, 5'd30);
      wait_drain();
      checks++;
      if (last_result !== 64'h1) begin failures++; $display("FAIL scalar_max: got %h, required 1", last_result); end
      check_sticky("scalar_max_sticky", 4'b1100);
   endtask

   task automatic test_back_to_back();
      bit ok;
      acc_edges.delete();
      out_edges.delete();
      out_ready = 1'b1;
      ok = 1;
      for (int i = 0; i < 8; i++) begin
         set_op({$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom), 2'($urandom), 5'(i + 8));
         in_valid = 1'b1;
         if (in_ready !== 1'b1) ok = 0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      wait_drain();
      checks++;
      if (!ok) begin failures++; $display("FAIL b2b_in_ready: in_ready dropped, required 1 throughout"); end
      checks++;
      if (acc_edges.size() != 8 || out_edges.size() != 8) begin
         failures++;
         $display("FAIL b2b_count: accepted=%0d outputs=%0d, required 8/8", acc_edges.size(), out_edges.size());
      end else begin
         ok = 1;
         for (int i = 0; i < 8; i++)
            if (out_edges[i] != acc_edges[0] + 2 + i) ok = 0;
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL b2b_timing: first output edge %0d, last %0d, required %0d..%0d",
                     out_edges[0], out_edges[7], acc_edges[0] + 2, acc_edges[0] + 9);
         end
      end
      check_sticky("b2b_sticky", exp_sticky);
   endtask

   task automatic test_stall();
      logic [63:0] a[3];
      logic [63:0] b[3];
      logic [2:0]  f[3];
      logic [1:0]  o[3];
      logic [63:0] held_res;
      logic [4:0]  held_tag;
      int unsigned idx, hs0;
      bit have, stable, acc, done;
      for (int i = 0; i < 3; i++) begin
         a[i] = {$urandom, $urandom}; b[i] = {$urandom, $urandom};
         f[i] = 3'($urandom); o[i] = 2'($urandom);
      end
      hs0 = hs_count;
      out_ready = 1'b0;
      idx = 0; have = 0; stable = 1;
      held_res = '0; held_tag = '0;
      for (int c = 0; c < 5; c++) begin
         if (idx < 3) begin
            set_op(a[idx], b[idx], f[idx], o[idx], 5'(20 + idx));
            in_valid = 1'b1;
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         if (out_valid) begin
            if (!have) begin held_res = result; held_tag = out_tag; have = 1; end
            else if (result !== held_res || out_tag !== held_tag) stable = 0;
         end
         @(posedge clk);
         #1;
         if (acc) idx++;
      end
      checks += 4;
      if (idx != 2) begin failures++; $display("FAIL stall_accepted: got %0d, required 2", idx); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
      if (!have || !stable) begin failures++; $display("FAIL stall_hold: out_valid seen=%0d stable=%0d, required 1/1", have, stable); end
      out_ready = 1'b1;
      #1;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_in_ready: got %b, required 1", in_ready); end
      done = 0;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) done = 1;
      end
      in_valid = 1'b0;
      wait_drain();
      checks++;
      if (hs_count - hs0 != 3) begin failures++; $display("FAIL stall_completed: got %0d, required 3", hs_count - hs0); end
      check_sticky("stall_sticky", exp_sticky);
   endtask

   task automatic test_sticky_clr();
      bit seen;
      out_ready = 1'b1;
      sticky_clr = 1'b1;
      @(posedge clk);
      #1;
      sticky_clr = 1'b0;
      check_sticky("sticky_clear", 4'b0000);
      drive(64'h8000_0000_0000_0005, 64'h0000_0001_0000_0007, {1'b0, `SIMD32}, 2'b01, 5'd5);
      wait_drain();
      check_sticky("sticky_set_1100", 4'b1100);
      out_ready = 1'b0;
      drive(64'h0001_7FFF_FFFF_0010, 64'h0001_0001_0001_0010, {1'b0, `SIMD16}, 2'b00, 5'd6);
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         if (out_valid) seen = 1;
         else begin @(posedge clk); #1; end
      end
      checks++;
      if (!seen) begin failures++; $display("FAIL sticky_wait_valid: out_valid=0, required 1"); end
      out_ready = 1'b1;
      sticky_clr = 1'b1;
      @(posedge clk);
      #1;
      sticky_clr = 1'b0;
      check_sticky("sticky_clr_coincident", 4'b0100);
      check_sticky("sticky_model", exp_sticky);
      wait_drain();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 3'b011, 2'b00, 5'd9);
      drive(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 3'b011, 2'b00, 5'd10);
      checks += 2;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL full_out_valid: got %b, required 1", out_valid); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready: got %b, required 0", in_ready); end
      #2;
      rst_n = 1'b0;
      out_ready = 1'b1;
      #1;
      checks += 3;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_out_valid: got %b, required 0", out_valid); end
      if (ovf_sticky !== 4'b0000) begin failures++; $display("FAIL mid_reset_sticky: got %b, required 0000", ovf_sticky); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_in_ready: got %b, required 1", in_ready); end
      sb_q.delete();
      exp_sticky = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_out_valid: got %b, required 0", out_valid); end
      drive(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 3'b011, 2'b00, 5'd11);
      wait_drain();
      check_sticky("post_reset_sticky", exp_sticky);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_simd16_add();
      test_simd32_sub();
      test_scalar_max();
      test_back_to_back();
      test_stall();
      test_sticky_clr();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
